// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive-side blocks: the word-packer FSM
// state encoding and the helper that sizes the character-count field.
package uart_pkg;

    // FILL collects characters from the RX FIFO; EMIT holds a finished word
    // on the output until the consumer takes it.
    typedef enum logic {
        ST_FILL = 1'b0,
        ST_EMIT = 1'b1
    } uart_rx_word_state_t;

    // The count field must hold BYTES_PER_WORD itself, so it needs one bit
    // more than $clog2 gives.
    function automatic int cnt_w(input int bytes_per_word);
        return $clog2(bytes_per_word) + 1;
    endfunction

endpackage

// File: rtl/uart_idle_timer.sv
// Saturating idle counter with synchronous clear and a compare-to-threshold
// expiry flag. A threshold of zero never expires.
module uart_idle_timer #(
    parameter int TIMEOUT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 arm,
    input  logic                 en,
    input  logic [TIMEOUT_W-1:0] threshold,
    output logic                 expire
);

    logic [TIMEOUT_W-1:0] count_q;
    logic [TIMEOUT_W-1:0] count_d;

    // Next count: clear wins, otherwise count up while enabled and stop at all-ones.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != '1)) begin
            count_d = count_q + TIMEOUT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Expiry is flagged in the cycle whose increment would reach the
    // threshold, so the owner leaves its idle state exactly threshold cycles
    // after the clear. Using >= also catches a threshold lowered below the
    // current count.
    always_comb begin
        expire = arm && (threshold != '0) && (count_q >= (threshold - TIMEOUT_W'(1)));
    end

endmodule

// File: rtl/uart_rx_word_ctrl.sv
// Drains the UART RX FWFT FIFO and packs characters into words for a
// valid/ready consumer. Words containing a parity error are tagged.
// Optional feature macro UART_RX_WORD_TIMEOUT_EN: when defined, a partial
// word is flushed after cfg_timeout idle cycles; when undefined, words are
// emitted only when full and cfg_timeout is ignored.
//
// Handshakes: the FIFO side pops its head on every cycle rx_req is high
// (rx_req is only raised when rx_ready is high); the output side transfers
// a word on every cycle with m_valid & m_ready, and m_data/m_count/m_err/
// m_timeout stay stable while m_valid is high and m_ready is low.
module uart_rx_word_ctrl
    import uart_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BYTES_PER_WORD = 4,
    parameter int TIMEOUT_W      = 16,
    parameter int CNT_W          = cnt_w(BYTES_PER_WORD)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cfg_enable,
    input  logic [TIMEOUT_W-1:0]            cfg_timeout,
    input  logic                            rx_ready,
    input  logic [WIDTH-1:0]                rx_data,
    input  logic                            parity_err,
    output logic                            rx_req,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [WIDTH*BYTES_PER_WORD-1:0] m_data,
    output logic [CNT_W-1:0]                m_count,
    output logic                            m_err,
    output logic                            m_timeout,
    output uart_rx_word_state_t             dbg_state
);

    localparam int DW = WIDTH * BYTES_PER_WORD;

    uart_rx_word_state_t state_q, state_d;
    logic [DW-1:0]       data_q, data_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                tmo_q, tmo_d;
    logic                pop;
    logic                timer_clr;
    logic                expire;

`ifdef UART_RX_WORD_TIMEOUT_EN
    logic timer_arm;
    logic timer_en;

    // The timer only runs while a partial word waits and nothing is popped.
    always_comb begin
        timer_arm = (state_q == ST_FILL) && (cnt_q != '0);
        timer_en  = timer_arm && !pop;
    end

    uart_idle_timer #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_idle_timer (
        .clk       (clk),
        .rst       (rst),
        .clr       (timer_clr),
        .arm       (timer_arm),
        .en        (timer_en),
        .threshold (cfg_timeout),
        .expire    (expire)
    );
`else
    logic unused_timer_inputs;

    // No idle flush in this build: words leave only when full.
    always_comb begin
        expire              = 1'b0;
        unused_timer_inputs = ^{cfg_timeout, timer_clr};
    end
`endif

    // Next-state and FIFO pop logic. A pop always beats a timer expiry in
    // the same cycle, and no pop is issued while reset is asserted.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        tmo_d     = tmo_q;
        pop       = 1'b0;
        timer_clr = 1'b0;
        case (state_q)
            ST_FILL: begin
                pop = cfg_enable && rx_ready && !rst;
                if (pop) begin
                    for (int i = 0; i < BYTES_PER_WORD; i++) begin
                        if (cnt_q == CNT_W'(i)) begin
                            data_d[i*WIDTH +: WIDTH] = rx_data;
                        end
                    end
                    cnt_d     = cnt_q + CNT_W'(1);
                    err_d     = err_q | parity_err;
                    timer_clr = 1'b1;
                    if (cnt_q == CNT_W'(BYTES_PER_WORD - 1)) begin
                        state_d = ST_EMIT;
                        tmo_d   = 1'b0;
                    end
                end else if (expire) begin
                    state_d = ST_EMIT;
                    tmo_d   = 1'b1;
                end
            end
            ST_EMIT: begin
                if (m_ready) begin
                    state_d   = ST_FILL;
                    data_d    = '0;
                    cnt_d     = '0;
                    err_d     = 1'b0;
                    tmo_d     = 1'b0;
                    timer_clr = 1'b1;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    // State and word registers; reset discards any partial or pending word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FILL;
            data_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    // Outputs come straight from registers except the FIFO pop strobe.
    always_comb begin
        rx_req    = pop;
        m_valid   = (state_q == ST_EMIT);
        m_data    = data_q;
        m_count   = cnt_q;
        m_err     = err_q;
        m_timeout = tmo_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_uart_rx_word_ctrl.sv
// Directed testbench for uart_rx_word_ctrl (WIDTH=8, BYTES_PER_WORD=4).
// Timeout scenarios run when UART_RX_WORD_TIMEOUT_EN is defined; otherwise
// the bench checks that partial words are never flushed.
module tb_uart_rx_word_ctrl;
    import uart_pkg::*;

    localparam int WIDTH = 8;
    localparam int BPW   = 4;
    localparam int TW    = 16;
    localparam int CNT_W = 3;
    localparam int DW    = 32;

    typedef struct packed {
        logic             par;
        logic [WIDTH-1:0] data;
    } fifo_ent_t;

    // Clock/reset and DUT signals
    logic                clk = 1'b0;
    logic                rst;
    logic                cfg_enable;
    logic [TW-1:0]       cfg_timeout;
    logic                rx_ready;
    logic [WIDTH-1:0]    rx_data;
    logic                parity_err;
    logic                rx_req;
    logic                m_valid;
    logic                m_ready;
    logic [DW-1:0]       m_data;
    logic [CNT_W-1:0]    m_count;
    logic                m_err;
    logic                m_timeout;
    uart_rx_word_state_t dbg_state;

    fifo_ent_t fifo_q[$];
    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    uart_rx_word_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_enable  (cfg_enable),
        .cfg_timeout (cfg_timeout),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .parity_err  (parity_err),
        .rx_req      (rx_req),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_count     (m_count),
        .m_err       (m_err),
        .m_timeout   (m_timeout),
        .dbg_state   (dbg_state)
    );

    // FIFO model: drive the head entry onto the read port.
    task automatic present();
        if (fifo_q.size() > 0) begin
            rx_ready   = 1'b1;
            rx_data    = fifo_q[0].data;
            parity_err = fifo_q[0].par;
        end else begin
            rx_ready   = 1'b0;
            rx_data    = '0;
            parity_err = 1'b0;
        end
    endtask

    task automatic push(input logic [WIDTH-1:0] d, input logic par);
        fifo_q.push_back({par, d});
        present();
    endtask

    // One clock cycle: sample rx_req mid-cycle, pass the edge, then retire
    // the popped entry from the FIFO model. Ends 1 ns after the edge.
    task automatic tick(output logic popped);
        #1;
        popped = rx_req;
        @(posedge clk);
        #1;
        if (popped && fifo_q.size() > 0) void'(fifo_q.pop_front());
        present();
    endtask

    task automatic check_word(input string name, input logic [DW-1:0] exp_data,
                              input logic [CNT_W-1:0] exp_cnt, input logic exp_err,
                              input logic exp_tmo);
        vectors++;
        if (m_valid !== 1'b1 || m_data !== exp_data || m_count !== exp_cnt ||
            m_err !== exp_err || m_timeout !== exp_tmo) begin
            miscompares++;
            $display("FAIL %s: got valid=%b data=%h count=%0d err=%b tmo=%b, expected valid=1 data=%h count=%0d err=%b tmo=%b",
                     name, m_valid, m_data, m_count, m_err, m_timeout,
                     exp_data, exp_cnt, exp_err, exp_tmo);
        end
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        cfg_enable  = 1'b1;
        cfg_timeout = '0;
        m_ready     = 1'b0;
        fifo_q.delete();
        push(8'hEE, 1'b0);
        #2;
        vectors++;
        if (rx_req !== 1'b0 || m_valid !== 1'b0 || m_data !== '0 || m_count !== '0 ||
            m_err !== 1'b0 || m_timeout !== 1'b0 || dbg_state !== ST_FILL) begin
            miscompares++;
            $display("FAIL reset_values: got req=%b valid=%b data=%h count=%0d err=%b tmo=%b state=%0d, expected all zero",
                     rx_req, m_valid, m_data, m_count, m_err, m_timeout, dbg_state);
        end
        @(posedge clk);
        #1;
        fifo_q.delete();
        present();
        rst = 1'b0;
    endtask

    task automatic test_full_word();
        logic p;
        m_ready = 1'b1;
        push(8'h11, 1'b0); push(8'h22, 1'b0); push(8'h33, 1'b0); push(8'h44, 1'b0);
        for (int i = 0; i < BPW; i++) begin
            tick(p);
            vectors++;
            if (p !== 1'b1) begin
                miscompares++;
                $display("FAIL full_rx_req[%0d]: got %b expected 1", i, p);
            end
        end
        check_word("full_word", 32'h44332211, 3'd4, 1'b0, 1'b0);
        tick(p);
        vectors++;
        if (m_valid !== 1'b0 || m_data !== '0 || m_count !== '0) begin
            miscompares++;
            $display("FAIL full_accept: got valid=%b data=%h count=%0d expected 0 0 0",
                     m_valid, m_data, m_count);
        end
    endtask

    task automatic test_back_to_back();
        logic          p;
        logic [DW-1:0] exp_q[$];
        logic          exp_err_q[$];
        int            exp_pop[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push(WIDTH'(i), (i == 3));
        exp_q.push_back(32'h04030201); exp_err_q.push_back(1'b1);
        exp_q.push_back(32'h08070605); exp_err_q.push_back(1'b0);
        for (int c = 0; c < 10; c++) begin
            if (m_valid === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL b2b_extra_word: got data=%h expected no word", m_data);
                end else begin
                    logic [DW-1:0] ed;
                    logic          ee;
                    ed = exp_q.pop_front();
                    ee = exp_err_q.pop_front();
                    if (m_data !== ed || m_err !== ee || m_count !== 3'd4) begin
                        miscompares++;
                        $display("FAIL b2b_word: got data=%h err=%b count=%0d expected data=%h err=%b count=4",
                                 m_data, m_err, m_count, ed, ee);
                    end
                end
            end
            tick(p);
            vectors++;
            if (p !== exp_pop[c][0]) begin
                miscompares++;
                $display("FAIL b2b_rx_req[%0d]: got %b expected %0d", c, p, exp_pop[c]);
            end
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_words_seen: got %0d missing expected 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        logic p;
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(8'h10 + WIDTH'(i), 1'b0);
        for (int i = 0; i < BPW; i++) tick(p);
        check_word("bp_first", 32'h13121110, 3'd4, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick(p);
            vectors++;
            if (p !== 1'b0 || m_valid !== 1'b1 || m_data !== 32'h13121110) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got req=%b valid=%b data=%h expected 0 1 13121110",
                         i, p, m_valid, m_data);
            end
        end
        m_ready = 1'b1;
        tick(p);
        vectors++;
        if (m_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_accept: got valid=%b expected 0", m_valid);
        end
        tick(p);
        vectors++;
        if (p !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_resume: got rx_req=%b expected 1", p);
        end
        for (int i = 0; i < BPW - 1; i++) tick(p);
        check_word("bp_second", 32'h17161514, 3'd4, 1'b0, 1'b0);
        tick(p);
    endtask

    task automatic test_enable();
        logic p;
        m_ready    = 1'b1;
        cfg_enable = 1'b0;
        push(8'hC1, 1'b0); push(8'hC2, 1'b0); push(8'hC3, 1'b0); push(8'hC4, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick(p);
            vectors++;
            if (p !== 1'b0 || m_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL disabled_no_pop[%0d]: got req=%b valid=%b expected 0 0", i, p, m_valid);
            end
        end
        cfg_enable = 1'b1;
        for (int i = 0; i < BPW; i++) tick(p);
        check_word("enable_word", 32'hC4C3C2C1, 3'd4, 1'b0, 1'b0);
        tick(p);
    endtask

    task automatic test_reset_mid_fill();
        logic p;
        m_ready = 1'b1;
        push(8'hA1, 1'b1); push(8'hA2, 1'b0); push(8'hA3, 1'b0); push(8'hA4, 1'b0);
        tick(p); tick(p);
        rst = 1'b1;
        #2;
        vectors++;
        if (rx_req !== 1'b0 || m_valid !== 1'b0 || m_data !== '0 || m_count !== '0 ||
            m_err !== 1'b0 || dbg_state !== ST_FILL) begin
            miscompares++;
            $display("FAIL midreset_values: got req=%b valid=%b data=%h count=%0d err=%b expected zeros",
                     rx_req, m_valid, m_data, m_count, m_err);
        end
        tick(p);
        vectors++;
        if (p !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_no_pop: got rx_req=%b expected 0", p);
        end
        rst = 1'b0;
        push(8'hB5, 1'b0); push(8'hB6, 1'b0);
        for (int i = 0; i < BPW; i++) tick(p);
        check_word("midreset_next", 32'hB6B5A4A3, 3'd4, 1'b0, 1'b0);
        tick(p);
    endtask

`ifdef UART_RX_WORD_TIMEOUT_EN
    task automatic test_timeout_flush();
        logic p;
        m_ready     = 1'b1;
        cfg_timeout = 16'd10;
        push(8'hA5, 1'b0); push(8'h5A, 1'b0);
        tick(p); tick(p);
        for (int k = 1; k <= 10; k++) begin
            tick(p);
            vectors++;
            if (m_valid !== (k == 10)) begin
                miscompares++;
                $display("FAIL timeout_latency[%0d]: got valid=%b expected %b", k, m_valid, (k == 10));
            end
        end
        check_word("timeout_word", 32'h00005AA5, 3'd2, 1'b0, 1'b1);
        tick(p);
        vectors++;
        if (m_valid !== 1'b0 || m_timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_accept: got valid=%b tmo=%b expected 0 0", m_valid, m_timeout);
        end
        cfg_timeout = '0;
    endtask

    task automatic test_collision();
        logic p;
        m_ready     = 1'b1;
        cfg_timeout = 16'd10;
        push(8'h77, 1'b0);
        tick(p);
        for (int k = 0; k < 9; k++) begin
            tick(p);
            vectors++;
            if (m_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL collide_wait[%0d]: got valid=%b expected 0", k, m_valid);
            end
        end
        push(8'h88, 1'b0);
        tick(p);
        vectors++;
        if (p !== 1'b1 || m_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL collide_pop_wins: got req=%b valid=%b expected 1 0", p, m_valid);
        end
        for (int k = 1; k <= 10; k++) begin
            tick(p);
            vectors++;
            if (m_valid !== (k == 10)) begin
                miscompares++;
                $display("FAIL collide_restart[%0d]: got valid=%b expected %b", k, m_valid, (k == 10));
            end
        end
        check_word("collide_word", 32'h00008877, 3'd2, 1'b0, 1'b1);
        tick(p);
        cfg_timeout = '0;
    endtask
`else
    task automatic test_no_timeout();
        logic p;
        m_ready     = 1'b1;
        cfg_timeout = 16'd3;
        push(8'h21, 1'b0); push(8'h22, 1'b0);
        tick(p); tick(p);
        for (int k = 0; k < 30; k++) begin
            tick(p);
            vectors++;
            if (m_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL no_flush[%0d]: got valid=%b expected 0", k, m_valid);
            end
        end
        push(8'h23, 1'b0); push(8'h24, 1'b0);
        tick(p); tick(p);
        check_word("no_flush_word", 32'h24232221, 3'd4, 1'b0, 1'b0);
        tick(p);
        cfg_timeout = '0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rx_ready   = 1'b0;
        rx_data    = '0;
        parity_err = 1'b0;
        test_reset();
        test_full_word();
        test_back_to_back();
        test_backpressure();
        test_enable();
        test_reset_mid_fill();
`ifdef UART_RX_WORD_TIMEOUT_EN
        test_timeout_flush();
        test_collision();
`else
        test_no_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx_word_ctrl.md
# uart_rx_word_ctrl

Receive-side controller that drains the UART RX FWFT FIFO and packs received characters into multi-byte words for a downstream valid/ready consumer (DMA or bus bridge). It sits between the `uart_rx_fifo` read port (`rx_req`/`rx_ready`/`rx_data`/`parity_err`) and the system fabric. It also flushes partially filled words after a programmable idle timeout and tags words containing parity errors.

## Interface
- `WIDTH`, 8: character width in bits; must match the RX FIFO.
- `BYTES_PER_WORD`, 4: characters packed per output word, ≥2.
- `TIMEOUT_W`, 16: width of the idle-timeout configuration.
- Derived `CNT_W = $clog2(BYTES_PER_WORD)+1`.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `cfg_enable`  in  1  allow popping the FIFO.
- `cfg_timeout`  in  TIMEOUT_W  idle cycles before a partial flush; 0 disables the flush.
- `rx_ready`  in  1  FIFO not empty; `rx_data` is valid.
- `rx_data`  in  WIDTH  FIFO head character.
- `parity_err`  in  1  parity flag of the head character.
- `rx_req`  out  1  pops the FIFO head this cycle.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  consumer accepts.
- `m_data`  out  WIDTH*BYTES_PER_WORD  packed word; byte 0 is in `[WIDTH-1:0]`.
- `m_count`  out  CNT_W  valid characters in the word, 1..BYTES_PER_WORD.
- `m_err`  out  1  at least one character in the word had a parity error.
- `m_timeout`  out  1  word was flushed by the timeout, not by filling.

## Operation
- **States:** FILL and EMIT. Reset state is FILL.
- **FILL:**
  - `rx_req = cfg_enable & rx_ready`. This is combinational; it is never asserted in EMIT.
  - On a pop, `rx_data` is written into lane `byte_cnt`, `parity_err` is ORed into the error flag, `byte_cnt` increments, and the timer is cleared.
  - A pop that makes `byte_cnt == BYTES_PER_WORD` moves to EMIT with `m_timeout = 0`.
- **Idle timer:**
  - Runs only in FILL with `byte_cnt > 0` and no pop. It saturates.
  - When it reaches `cfg_timeout` (≠0), the block moves to EMIT with `m_timeout = 1`.
  - A pop in the same cycle as the expiry wins: the character is captured and the timer is cleared.
- **EMIT:**
  - `m_valid = 1`. `m_data`, `m_count`, `m_err` and `m_timeout` are registered and held stable until `m_ready`.
  - On the `m_valid & m_ready` cycle, lanes, count, flags and timer clear and the block returns to FILL.
- **Unused lanes:** lanes at index ≥ `m_count` read zero.
- **`cfg_enable` deasserted:**
  - No pops occur.
  - A partial word still times out and is emitted.
  - A word already in EMIT completes normally.
- **`cfg_timeout` change:** takes effect immediately and is compared against the current timer value.
- **Reset mid-operation:** the partial word and the pending output are discarded. No FIFO pop happens during reset.

## Timing
- **Reset values:** `rx_req=0`, `m_valid=0`, `m_data=0`, `m_count=0`, `m_err=0`, `m_timeout=0`. The state register reset value is FILL.
- **Fill latency:** the pop of the last character is in cycle P; `m_valid` is high in cycle P+1.
- **Timeout latency:** the last pop is in cycle P and no further pops occur; `m_valid` is high in cycle P+T+1, where T = `cfg_timeout`.
- **Throughput:** at best one word per `BYTES_PER_WORD+1` cycles, since there is a minimum of one EMIT cycle and no pop in EMIT.
- **Backpressure:** the FIFO absorbs it while `m_ready` is low.

## Configuration
- Macro `UART_RX_WORD_TIMEOUT_EN`.
- **Defined:** idle-timer flush as described above.
- **Undefined:**
  - The timer logic is removed and `cfg_timeout` is ignored.
  - Words are emitted only when full.
  - `m_timeout` is tied to 0 and `m_count` is always `BYTES_PER_WORD`.

## Structure
- Shared package `uart_pkg`:
  - state enum `uart_rx_word_state_t` (FILL, EMIT);
  - `CNT_W` computation helper.
- One sub-module, `uart_idle_timer`: a saturating counter with clear, enable and compare-to-threshold expiry output. It is instantiated only under `UART_RX_WORD_TIMEOUT_EN`.

## Test plan
- **Full word:** `BYTES_PER_WORD=4`, `m_ready=1`, FIFO holds 0x11,0x22,0x33,0x44 → `rx_req` for 4 consecutive cycles; one cycle later `m_data=0x44332211`, `m_count=4`, `m_err=0`, `m_timeout=0`.
- **Timeout flush:** `cfg_timeout=10`, 2 characters 0xA5,0x5A then FIFO empty → `m_valid` rises 11 cycles after the second pop; `m_data=0x00005AA5`, `m_count=2`, `m_timeout=1`.
- **Parity tagging:** the third character arrives with `parity_err=1` → the word has `m_err=1`; the next word has `m_err=0`.
- **Backpressure:** `m_ready=0` for 20 cycles with the FIFO non-empty → `rx_req` stays 0 and `m_data` is stable. `m_ready=1` → accepted, and popping resumes on the next cycle.
- **Expiry collision:** a pop lands on the exact timer-expiry cycle → the character is captured, no flush occurs, and the timer restarts.
- **Reset mid-fill:** `rst` is pulsed after 2 pops → outputs return to reset values, and the next word starts at lane 0 with `m_count` counting from 0.
